// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module  : control_unit
// Brief   : Hardwired Moore control sequencer for the 32-bit CPU datapath.
//           Define CU_INSTR_COUNT_EN to add the instr_count retired counter.
// Revision: 1.0  initial release
// ============================================================================
module control_unit #(
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        stop,
`ifdef CU_INSTR_COUNT_EN
    output logic [31:0] instr_count,
`endif
    output logic        run,
    output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
    output logic        PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, CONin, OutPort,
    output logic        Gra, Grb, Grc, Rin, Rout,
    output logic        read, write,
    output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC
);

    localparam logic [OPW-1:0] c_op_ld   = OPW'(0),  c_op_ldi  = OPW'(1),  c_op_st   = OPW'(2);
    localparam logic [OPW-1:0] c_op_add  = OPW'(3),  c_op_sub  = OPW'(4),  c_op_shr  = OPW'(5);
    localparam logic [OPW-1:0] c_op_shl  = OPW'(6),  c_op_ror  = OPW'(7),  c_op_rol  = OPW'(8);
    localparam logic [OPW-1:0] c_op_and  = OPW'(9),  c_op_or   = OPW'(10), c_op_addi = OPW'(11);
    localparam logic [OPW-1:0] c_op_andi = OPW'(12), c_op_ori  = OPW'(13), c_op_mul  = OPW'(14);
    localparam logic [OPW-1:0] c_op_div  = OPW'(15), c_op_neg  = OPW'(16), c_op_not  = OPW'(17);
    localparam logic [OPW-1:0] c_op_br   = OPW'(18), c_op_jr   = OPW'(19), c_op_jal  = OPW'(20);
    localparam logic [OPW-1:0] c_op_in   = OPW'(21), c_op_out  = OPW'(22), c_op_mfhi = OPW'(23);
    localparam logic [OPW-1:0] c_op_mflo = OPW'(24), c_op_halt = OPW'(26);

    typedef enum logic [3:0] {
        S_RST, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t         r_state;
    state_t         w_last;
    state_t         w_step_next;
    logic [OPW-1:0] w_op;
    logic           w_alu3;
    logic           w_unused_ir;

    assign w_op        = ir[31 -: OPW];
    assign w_unused_ir = ^ir[31-OPW:0];
    assign w_alu3      = (w_op >= c_op_add) && (w_op <= c_op_or);

    // Final execute step of each opcode; anything unlisted is a single-step no-op.
    always_comb begin
        w_last = S_T3;
        case (w_op)
            c_op_ld, c_op_st:                                   w_last = S_T7;
            c_op_ldi, c_op_add, c_op_sub, c_op_shr, c_op_shl,
            c_op_ror, c_op_rol, c_op_and, c_op_or,
            c_op_addi, c_op_andi, c_op_ori:                     w_last = S_T5;
            c_op_mul, c_op_div, c_op_br:                        w_last = S_T6;
            c_op_neg, c_op_not, c_op_jal:                       w_last = S_T4;
            default:                                            w_last = S_T3;
        endcase
    end

    always_comb begin
        w_step_next = S_F0;
        case (r_state)
            S_T3:    w_step_next = S_T4;
            S_T4:    w_step_next = S_T5;
            S_T5:    w_step_next = S_T6;
            S_T6:    w_step_next = S_T7;
            default: w_step_next = S_F0;
        endcase
    end

    // stop is honoured only at the instruction boundary.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= S_RST;
        end else begin
            case (r_state)
                S_RST:  r_state <= S_F0;
                S_F0:   r_state <= S_F1;
                S_F1:   r_state <= S_F2;
                S_F2:   r_state <= (w_op == c_op_halt) ? S_HALT : S_T3;
                S_HALT: r_state <= S_HALT;
                S_T3, S_T4, S_T5, S_T6, S_T7: begin
                    if (r_state == w_last) r_state <= stop ? S_HALT : S_F0;
                    else                   r_state <= w_step_next;
                end
                default: r_state <= S_RST;
            endcase
        end
    end

`ifdef CU_INSTR_COUNT_EN
    logic [31:0] r_instr_count;
    logic        w_done;

    assign w_done      = (r_state == w_last);
    assign instr_count = r_instr_count;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear)      r_instr_count <= '0;
        else if (w_done) r_instr_count <= r_instr_count + 32'd1;
    end
`endif

    always_comb begin
        run   = (r_state != S_RST) && (r_state != S_HALT);
        PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; Inportout = 1'b0; Cout = 1'b0; BAout = 1'b0;
        PCin  = 1'b0; IRin = 1'b0; MARin = 1'b0; Yin = 1'b0; Zin = 1'b0; MDRin = 1'b0;
        HIin  = 1'b0; LOin = 1'b0; CONin = 1'b0; OutPort = 1'b0;
        Gra   = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        read  = 1'b0; write = 1'b0;
        AND   = 1'b0; OR = 1'b0; ADD = 1'b0; SUB = 1'b0; MUL = 1'b0; DIV = 1'b0;
        SHR   = 1'b0; SHL = 1'b0; ROR = 1'b0; ROL = 1'b0; NEG = 1'b0; NOT = 1'b0; IncPC = 1'b0;
        case (r_state)
            S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_F1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
            S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (w_op)
                    c_op_ld, c_op_ldi, c_op_st: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    c_op_add, c_op_sub, c_op_shr, c_op_shl, c_op_ror, c_op_rol, c_op_and,
                    c_op_or, c_op_addi, c_op_andi, c_op_ori: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    c_op_mul, c_op_div: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    c_op_neg, c_op_not: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        NEG = (w_op == c_op_neg); NOT = (w_op == c_op_not);
                    end
                    c_op_br:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    c_op_jr:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    c_op_jal:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    c_op_in:   begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    c_op_out:  begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
                    c_op_mfhi: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    c_op_mflo: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                if (w_alu3) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    ADD = (w_op == c_op_add); SUB = (w_op == c_op_sub);
                    SHR = (w_op == c_op_shr); SHL = (w_op == c_op_shl);
                    ROR = (w_op == c_op_ror); ROL = (w_op == c_op_rol);
                    AND = (w_op == c_op_and); OR  = (w_op == c_op_or);
                end else begin
                    case (w_op)
                        c_op_ld, c_op_ldi, c_op_st: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                        c_op_addi, c_op_andi, c_op_ori: begin
                            Cout = 1'b1; Zin = 1'b1;
                            ADD = (w_op == c_op_addi); AND = (w_op == c_op_andi); OR = (w_op == c_op_ori);
                        end
                        c_op_mul, c_op_div: begin
                            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                            MUL = (w_op == c_op_mul); DIV = (w_op == c_op_div);
                        end
                        c_op_neg, c_op_not: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        c_op_br:  begin PCout = 1'b1; Yin = 1'b1; end
                        c_op_jal: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T5: begin
                if (w_op == c_op_ld || w_op == c_op_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (w_op == c_op_ldi || w_alu3 || w_op == c_op_addi ||
                             w_op == c_op_andi || w_op == c_op_ori) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_op == c_op_mul || w_op == c_op_div) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (w_op == c_op_br) begin
                    Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                end
            end
            S_T6: begin
                case (w_op)
                    c_op_ld:            begin read = 1'b1; MDRin = 1'b1; end
                    c_op_st:            begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    c_op_mul, c_op_div: begin Zhighout = 1'b1; HIin = 1'b1; end
                    c_op_br:            begin Zlowout = con; PCin = con; end
                    default: ;
                endcase
            end
            S_T7: begin
                if (w_op == c_op_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (w_op == c_op_st) write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_unit
// Brief   : Scoreboard bench for control_unit; expected control words are
//           queued from an opcode table and popped as each step is observed.
// Revision: 1.0  initial release
// ============================================================================
module tb_control_unit;

    localparam int I_RUN = 39, I_PCOUT = 38, I_MDROUT = 37, I_ZHI = 36, I_ZLO = 35;
    localparam int I_HIOUT = 34, I_LOOUT = 33, I_INPORT = 32, I_COUT = 31, I_BAOUT = 30;
    localparam int I_PCIN = 29, I_IRIN = 28, I_MARIN = 27, I_YIN = 26, I_ZIN = 25;
    localparam int I_MDRIN = 24, I_HIIN = 23, I_LOIN = 22, I_CONIN = 21, I_OUTPORT = 20;
    localparam int I_GRA = 19, I_GRB = 18, I_GRC = 17, I_RIN = 16, I_ROUT = 15;
    localparam int I_READ = 14, I_WRITE = 13, I_AND = 12, I_OR = 11, I_ADD = 10;
    localparam int I_SUB = 9, I_MUL = 8, I_DIV = 7, I_SHR = 6, I_SHL = 5;
    localparam int I_ROR = 4, I_ROL = 3, I_NEG = 2, I_NOT = 1, I_INCPC = 0;

    logic        clk;
    logic        clear, con, stop;
    logic [31:0] ir;
    logic        run;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout;
    logic        PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, CONin, OutPort;
    logic        Gra, Grb, Grc, Rin, Rout, read, write;
    logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
`ifdef CU_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif
    logic [39:0] obs;

    logic [39:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    control_unit #(.OPW(5)) dut (
        .clk(clk), .clear(clear), .ir(ir), .con(con), .stop(stop),
`ifdef CU_INSTR_COUNT_EN
        .instr_count(instr_count),
`endif
        .run(run),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Inportout(Inportout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin), .MDRin(MDRin),
        .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPort(OutPort),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .read(read), .write(write),
        .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC)
    );

    assign obs = {run, PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout,
                  PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, CONin, OutPort,
                  Gra, Grb, Grc, Rin, Rout, read, write,
                  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] b(input int i);
        return 40'd1 << i;
    endfunction

    function automatic int op_bit(input int op);
        case (op)
            3, 11:   return I_ADD;
            4:       return I_SUB;
            5:       return I_SHR;
            6:       return I_SHL;
            7:       return I_ROR;
            8:       return I_ROL;
            9, 12:   return I_AND;
            10, 13:  return I_OR;
            14:      return I_MUL;
            15:      return I_DIV;
            16:      return I_NEG;
            default: return I_NOT;
        endcase
    endfunction

    // Reference table: fetch words then the execute words for one opcode.
    task automatic push_instr(input int op, input bit cfin);
        logic [39:0] r;
        logic [39:0] w[$];
        r = b(I_RUN);
        w.push_back(r | b(I_PCOUT) | b(I_MARIN) | b(I_INCPC) | b(I_ZIN));
        w.push_back(r | b(I_ZLO) | b(I_PCIN) | b(I_READ) | b(I_MDRIN));
        w.push_back(r | b(I_MDROUT) | b(I_IRIN));
        if (op <= 2) begin
            w.push_back(r | b(I_GRB) | b(I_BAOUT) | b(I_YIN));
            w.push_back(r | b(I_COUT) | b(I_ADD) | b(I_ZIN));
            if (op == 1) begin
                w.push_back(r | b(I_ZLO) | b(I_GRA) | b(I_RIN));
            end else begin
                w.push_back(r | b(I_ZLO) | b(I_MARIN));
                w.push_back((op == 0) ? (r | b(I_READ) | b(I_MDRIN)) : (r | b(I_GRA) | b(I_ROUT) | b(I_MDRIN)));
                w.push_back((op == 0) ? (r | b(I_MDROUT) | b(I_GRA) | b(I_RIN)) : (r | b(I_WRITE)));
            end
        end else if (op <= 10) begin
            w.push_back(r | b(I_GRB) | b(I_ROUT) | b(I_YIN));
            w.push_back(r | b(I_GRC) | b(I_ROUT) | b(op_bit(op)) | b(I_ZIN));
            w.push_back(r | b(I_ZLO) | b(I_GRA) | b(I_RIN));
        end else if (op <= 13) begin
            w.push_back(r | b(I_GRB) | b(I_ROUT) | b(I_YIN));
            w.push_back(r | b(I_COUT) | b(op_bit(op)) | b(I_ZIN));
            w.push_back(r | b(I_ZLO) | b(I_GRA) | b(I_RIN));
        end else if (op <= 15) begin
            w.push_back(r | b(I_GRA) | b(I_ROUT) | b(I_YIN));
            w.push_back(r | b(I_GRB) | b(I_ROUT) | b(op_bit(op)) | b(I_ZIN));
            w.push_back(r | b(I_ZLO) | b(I_LOIN));
            w.push_back(r | b(I_ZHI) | b(I_HIIN));
        end else if (op <= 17) begin
            w.push_back(r | b(I_GRB) | b(I_ROUT) | b(op_bit(op)) | b(I_ZIN));
            w.push_back(r | b(I_ZLO) | b(I_GRA) | b(I_RIN));
        end else begin
            case (op)
                18: begin
                    w.push_back(r | b(I_GRA) | b(I_ROUT) | b(I_CONIN));
                    w.push_back(r | b(I_PCOUT) | b(I_YIN));
                    w.push_back(r | b(I_COUT) | b(I_ADD) | b(I_ZIN));
                    w.push_back(cfin ? (r | b(I_ZLO) | b(I_PCIN)) : r);
                end
                19: w.push_back(r | b(I_GRA) | b(I_ROUT) | b(I_PCIN));
                20: begin
                    w.push_back(r | b(I_PCOUT) | b(I_GRB) | b(I_RIN));
                    w.push_back(r | b(I_GRA) | b(I_ROUT) | b(I_PCIN));
                end
                21: w.push_back(r | b(I_INPORT) | b(I_GRA) | b(I_RIN));
                22: w.push_back(r | b(I_GRA) | b(I_ROUT) | b(I_OUTPORT));
                23: w.push_back(r | b(I_HIOUT) | b(I_GRA) | b(I_RIN));
                24: w.push_back(r | b(I_LOOUT) | b(I_GRA) | b(I_RIN));
                26: ;
                default: w.push_back(r);
            endcase
        end
        for (int k = 0; k < w.size(); k++) begin
            exp_q.push_back(w[k]);
            tag_q.push_back($sformatf("op%0d_step%0d", op, k));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear = 1'b0; stop = 1'b0; con = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
    endtask

    task automatic test_reset();
        logic [39:0] e;
        string t;
        clear = 1'b1; stop = 1'b0; con = 1'b0; ir = 32'h0;
        #2 clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(40'd0);
            tag_q.push_back($sformatf("reset_idle%0d", k));
        end
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, obs, e); end
        end
        clear = 1'b1;
    endtask

    // Back-to-back sweep of every opcode except br (own test) and halt.
    task automatic test_opcodes();
        logic [39:0] e;
        string t;
        int n;
        for (int op = 0; op < 32; op++) begin
            if (op == 18 || op == 26) continue;
            @(posedge clk); #1;
            ir = (op == 3) ? 32'h1A2B8000 : {op[4:0], 27'h0123456};
            push_instr(op, 1'b0);
            n = exp_q.size();
            for (int k = 0; k < n; k++) begin
                if (k > 0) begin @(posedge clk); #1; end
                e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
                if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, obs, e); end
            end
        end
    endtask

    // con is swung during T3-T5 and settles to its final value only for T6.
    task automatic test_branch();
        logic [39:0] e;
        string t;
        int n;
        bit fin, pre;
        for (int i = 0; i < 4; i++) begin
            fin = i[0];
            pre = i[1] ? fin : ~fin;
            @(posedge clk); #1;
            ir = {5'b10010, 27'h0400000};
            con = pre;
            push_instr(18, fin);
            n = exp_q.size();
            for (int k = 0; k < n; k++) begin
                if (k > 0) begin @(posedge clk); #1; end
                e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
                if (obs !== e) begin errors++; $display("FAIL br%0d_%s: got %h expected %h", i, t, obs, e); end
                if (k == 5) con = fin;
            end
        end
        con = 1'b0;
    endtask

    task automatic test_store_clear();
        logic [39:0] e;
        string t;
        int n;
        @(posedge clk); #1;
        ir = {5'b00010, 27'h0000001};
        push_instr(2, 1'b0);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL st_%s: got %h expected %h", t, obs, e); end
        end
        @(posedge clk); #1;
        push_instr(2, 1'b0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL abort_%s: got %h expected %h", t, obs, e); end
        end
        exp_q.delete(); tag_q.delete();
        clear = 1'b0;
        #1;
        checks++;
        if (obs !== 40'd0) begin errors++; $display("FAIL abort_async: got %h expected %h", obs, 40'd0); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 40'd0) begin errors++; $display("FAIL abort_hold%0d: got %h expected %h", k, obs, 40'd0); end
        end
        clear = 1'b1;
    endtask

    task automatic test_stop_halt();
        logic [39:0] e;
        string t;
        int n;
        @(posedge clk); #1;
        ir = {5'b01110, 27'h0000002};
        push_instr(14, 1'b0);
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(40'd0);
            tag_q.push_back($sformatf("stop_halt%0d", k));
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL mulstop_%s: got %h expected %h", t, obs, e); end
            if (k == 4)  stop = 1'b1;
            if (k == 12) stop = 1'b0;
        end
    endtask

    task automatic test_halt_opcode();
        logic [39:0] e;
        string t;
        int n;
        apply_reset();
        @(posedge clk); #1;
        ir = {5'b11010, 27'h0000000};
        push_instr(26, 1'b0);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(40'd0);
            tag_q.push_back($sformatf("halt_op_idle%0d", k));
        end
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", t, obs, e); end
            if (k == 3) ir = {5'b11001, 27'h0};
        end
    endtask

`ifdef CU_INSTR_COUNT_EN
    task automatic test_instr_count();
        apply_reset();
        checks++;
        if (instr_count !== 32'd0) begin errors++; $display("FAIL count_reset: got %0d expected 0", instr_count); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ir = {5'b11001, 27'h0};
            checks++;
            if (instr_count !== 32'(i)) begin errors++; $display("FAIL count_nop%0d: got %0d expected %0d", i, instr_count, i); end
            repeat (3) @(posedge clk);
        end
        @(posedge clk); #1;
        ir = {5'b11010, 27'h0};
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if (instr_count !== 32'd5) begin errors++; $display("FAIL count_hold%0d: got %0d expected 5", k, instr_count); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_opcodes();
        test_branch();
        test_store_clear();
        test_stop_halt();
        test_halt_opcode();
`ifdef CU_INSTR_COUNT_EN
        test_instr_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer driving the 32-bit CPU datapath's control inputs (register in/out enables, ALU op strobes, memory read/write, select/encode controls).
- Consumes IR and the branch condition flag from the datapath.
- Emits one control-word per step: fetch in three steps, then a per-opcode execute sequence, then back to fetch.
- Sits beside the datapath in the CPU top level.

Parameters:
- OPW, 5, opcode width; opcode is IR[31:27].

Ports:
- clk  in  1  system clock, rising edge
- clear  in  1  reset, asynchronous, active-low
- ir  in  32  instruction register contents
- con  in  1  branch condition flip-flop output
- stop  in  1  request halt at the next instruction boundary
- run  out  1  high while executing, low in reset and halt
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout, BAout  out  1 each  bus source selects
- PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, CONin, OutPort  out  1 each  register load enables
- Gra, Grb, Grc, Rin, Rout  out  1 each  select/encode controls
- read, write  out  1 each  memory/MDR controls
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC  out  1 each  ALU operation strobes

Behaviour:
- Outputs are a pure decode of the registered state and ir; no output is registered separately.
- While clear=0 and in the reset state: every output is 0 and run=0.
- First rising edge after clear rises enters F0; run=1 from F0 onward.
- Fetch sequence:
  - F0: PCout, MARin, IncPC, Zin
  - F1: Zlowout, PCin, read, MDRin
  - F2: MDRout, IRin
- After F2, opcode = ir[31:27] selects the execute sequence. Every unlisted output is 0 in each step.
- Opcodes 00000 ld, 00000xx immediate group not used; decoded opcode map:
  - 00000 ld: T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,MARin; T6 read,MDRin; T7 MDRout,Gra,Rin
  - 00001 ldi: T3–T4 as ld; T5 Zlowout,Gra,Rin
  - 00010 st: T3–T5 as ld; T6 Gra,Rout,MDRin (read=0 selects bus); T7 write
  - 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or: T3 Grb,Rout,Yin; T4 Grc,Rout,<op>,Zin; T5 Zlowout,Gra,Rin
  - 01011 addi, 01100 andi, 01101 ori: T3 Grb,Rout,Yin; T4 Cout,<ADD|AND|OR>,Zin; T5 Zlowout,Gra,Rin
  - 01110 mul, 01111 div: T3 Gra,Rout,Yin; T4 Grb,Rout,<op>,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin
  - 10000 neg, 10001 not: T3 Grb,Rout,<op>,Zin; T4 Zlowout,Gra,Rin
  - 10010 br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout,PCin only if con=1, otherwise all outputs 0
  - 10011 jr: T3 Gra,Rout,PCin
  - 10100 jal: T3 PCout,Grb,Rin (link into Rb); T4 Gra,Rout,PCin
  - 10101 in: T3 Inportout,Gra,Rin
  - 10110 out: T3 Gra,Rout,OutPort
  - 10111 mfhi: T3 HIout,Gra,Rin
  - 11000 mflo: T3 LOout,Gra,Rin
  - 11001 nop, and all opcodes 11011–11111: zero-output T3
  - 11010 halt: enter HALT
- con is sampled only in br T6; a change in con at any other time has no effect.
- After the last step of any sequence, next state is F0. If stop=1 on that edge, next state is HALT instead.
- stop has no effect mid-instruction.
- HALT: all outputs 0, run=0. Only clear exits HALT.
- clear asserted at any step aborts immediately and asynchronously to reset; a partial st never issues write.
- Instruction length in cycles = 3 fetch + execute steps: add 6, ld 8, st 8, mul 7, br 7, jr 4, nop 4.

Optional Feature:
- Macro: CU_INSTR_COUNT_EN.
- When defined: adds output instr_count[31:0].
  - Reset value 0.
  - Increments by 1 on the edge leaving the last execute step of every instruction, including nop.
  - halt does not count.
  - Wraps from FFFFFFFF to 0.
- When not defined: port absent; behaviour otherwise identical.

Test Plan:
- Reset release with ir=0 → cycle 1: PCout=MARin=IncPC=Zin=1, run=1; cycle 3: MDRout=IRin=1.
- ir=0x1A2B8000 (add R4,R5,R7) → T3 Grb,Rout,Yin; T4 Grc,Rout,ADD,Zin; T5 Zlowout,Gra,Rin; F0 on the 7th cycle.
- ir opcode 00010 (st) → read=0 with MDRin=1 in T6; write=1 only in T7; clear pulsed in T6 → write never asserts.
- ir opcode 10010 with con=0 → T6 has PCin=0; repeat with con=1 → T6 has Zlowout=PCin=1.
- stop=1 raised during T4 of mul → completes T6 (HIin=1), then HALT: run=0 and all outputs 0 for 20 cycles.
- With CU_INSTR_COUNT_EN: 5 nops then halt → instr_count=5 and holds.
